// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC bus responder:
// FSM encoding, bus width and default command address.
package rtc_pkg;

    localparam int BUS_W = 8;
    localparam logic [BUS_W-1:0] CMD_ADDR_DEF = 8'hF0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        DATA_WAIT = 3'd2,
        WRITE     = 3'd3,
        READ      = 3'd4
    } state_e;

endpackage

// File: rtl/rtc_sync_edge.sv
// Two-flop synchronizer for one control line, with a
// rising-edge detect on the synchronized value.
module rtc_sync_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_in,
    output logic q,
    output logic rise
);

    logic s1_q;
    logic s2_q;
    logic prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q   <= RST_VAL;
            s2_q   <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            s1_q   <= d_in;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign q    = s2_q;
    assign rise = s2_q & ~prev_q;

endmodule

// File: rtl/rtc_bus_responder.sv
// Bus responder emulating a small RTC register file behind a
// multiplexed address/data strobe interface.
import rtc_pkg::*;

module rtc_bus_responder #(
    parameter int NREG = 16,
    parameter logic [BUS_W-1:0] CMD_ADDR = CMD_ADDR_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs_n,
    input  logic             wr_n,
    input  logic             rd_n,
    input  logic             ad,
    input  logic [BUS_W-1:0] bus_in,
    output logic [BUS_W-1:0] bus_out,
    output logic             bus_oe,
    output logic             upd,
    output logic             wr_evt,
    output logic [BUS_W-1:0] evt_addr,
    output logic [BUS_W-1:0] evt_data
);

    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [BUS_W:0] NREG_L = (BUS_W+1)'(NREG);

    logic cs_s, wr_s, rd_s;
    logic cs_rise, wr_rise, rd_rise;

    rtc_sync_edge u_cs (
        .clk(clk), .reset(reset), .d_in(cs_n), .q(cs_s), .rise(cs_rise)
    );
    rtc_sync_edge u_wr (
        .clk(clk), .reset(reset), .d_in(wr_n), .q(wr_s), .rise(wr_rise)
    );
    rtc_sync_edge u_rd (
        .clk(clk), .reset(reset), .d_in(rd_n), .q(rd_s), .rise(rd_rise)
    );

    // ad and bus_in share the control lines' two-flop latency
    logic             ad_s1_q, ad_q;
    logic [BUS_W-1:0] bus_s1_q, bus_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ad_s1_q  <= 1'b1;
            ad_q     <= 1'b1;
            bus_s1_q <= '0;
            bus_q    <= '0;
        end else begin
            ad_s1_q  <= ad;
            ad_q     <= ad_s1_q;
            bus_s1_q <= bus_in;
            bus_q    <= bus_s1_q;
        end
    end

    state_e           state_q, state_d;
    logic [BUS_W-1:0] cand_q, cand_d;
    logic [BUS_W-1:0] addr_q, addr_d;
    logic [BUS_W-1:0] dat_q, dat_d;
    logic [BUS_W-1:0] regs_q [NREG];
    logic [BUS_W-1:0] regs_d [NREG];
    logic             oe_q, oe_d;
    logic [BUS_W-1:0] bus_out_q, bus_out_d;
    logic             upd_q, upd_d;
    logic             wr_evt_q, wr_evt_d;
    logic [BUS_W-1:0] evt_addr_q, evt_addr_d;
    logic [BUS_W-1:0] evt_data_q, evt_data_d;

    logic             commit;
    logic             both_low;
    logic             new_addr;
    logic             in_range;
    logic [BUS_W-1:0] rd_val;

    assign both_low = ~wr_s & ~rd_s;
    assign new_addr = ~cs_s & ~wr_s & ~ad_q;
    assign in_range = {1'b0, addr_q} < NREG_L;
    assign rd_val   = in_range ? regs_q[addr_q[AW-1:0]] : '0;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        addr_d  = addr_q;
        dat_d   = dat_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (new_addr) state_d = ADDR;
            end
            ADDR: begin
                cand_d = bus_q;
                if (both_low) begin
                    state_d = IDLE;
                end else if (wr_rise) begin
                    addr_d  = cand_q;
                    state_d = DATA_WAIT;
                end else if (cs_rise) begin
                    state_d = IDLE;
                end
            end
            DATA_WAIT: begin
                if (both_low) begin
                    state_d = IDLE;
                end else if (new_addr) begin
                    state_d = ADDR;
                end else if (~cs_s & ~wr_s & ad_q) begin
                    state_d = WRITE;
                end else if (~cs_s & ~rd_s & ad_q) begin
                    state_d = READ;
                end
            end
            WRITE: begin
                dat_d = bus_q;
                if (both_low) begin
                    state_d = IDLE;
                end else if (wr_rise) begin
                    commit  = 1'b1;
                    state_d = DATA_WAIT;
                end else if (cs_rise) begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (both_low || cs_rise) begin
                    state_d = IDLE;
                end else if (rd_rise) begin
                    state_d = DATA_WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (commit && in_range) regs_d[addr_q[AW-1:0]] = dat_q;
        wr_evt_d   = commit;
        upd_d      = commit && (addr_q == CMD_ADDR);
        evt_addr_d = commit ? addr_q : evt_addr_q;
        evt_data_d = commit ? dat_q : evt_data_q;
        oe_d       = (state_q == READ) && (state_d == READ);
        bus_out_d  = bus_out_q;
        // Load read data once per READ entry so it holds while driven
        if (oe_d && !oe_q) bus_out_d = rd_val;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cand_q     <= '0;
            addr_q     <= '0;
            dat_q      <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            oe_q       <= 1'b0;
            bus_out_q  <= '0;
            upd_q      <= 1'b0;
            wr_evt_q   <= 1'b0;
            evt_addr_q <= '0;
            evt_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            addr_q     <= addr_d;
            dat_q      <= dat_d;
            regs_q     <= regs_d;
            oe_q       <= oe_d;
            bus_out_q  <= bus_out_d;
            upd_q      <= upd_d;
            wr_evt_q   <= wr_evt_d;
            evt_addr_q <= evt_addr_d;
            evt_data_q <= evt_data_d;
        end
    end

    // Drive enable drops in the very cycle the FSM decides to leave READ
    assign bus_oe   = oe_q && (state_q == READ) && (state_d == READ);
    assign bus_out  = bus_out_q;
    assign upd      = upd_q;
    assign wr_evt   = wr_evt_q;
    assign evt_addr = evt_addr_q;
    assign evt_data = evt_data_q;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Self-checking bench for rtc_bus_responder: directed cases plus
// random register traffic checked against an array model.
module tb_rtc_bus_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs_n, wr_n, rd_n, ad;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_oe, upd, wr_evt;
    logic [7:0] evt_addr, evt_data;

    rtc_bus_responder dut (
        .clk(clk), .reset(reset), .cs_n(cs_n), .wr_n(wr_n),
        .rd_n(rd_n), .ad(ad), .bus_in(bus_in), .bus_out(bus_out),
        .bus_oe(bus_oe), .upd(upd), .wr_evt(wr_evt),
        .evt_addr(evt_addr), .evt_data(evt_data)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] m [16];
    int         evt_cnt, upd_cnt, upd_alone, stray_oe;
    logic [7:0] last_ea, last_ed;
    bit         oe_allow = 1'b0;

    task automatic check8(input string tag, input logic [7:0] obs,
                          input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (wr_evt === 1'b1) begin
            evt_cnt++;
            last_ea = evt_addr;
            last_ed = evt_data;
        end
        if (upd === 1'b1) upd_cnt++;
        if (upd === 1'b1 && wr_evt !== 1'b1) upd_alone++;
        if (bus_oe !== 1'b0 && !oe_allow) stray_oe++;
    endtask

    task automatic clr_mon();
        evt_cnt   = 0;
        upd_cnt   = 0;
        upd_alone = 0;
        stray_oe  = 0;
    endtask

    function automatic logic [7:0] exp_rd(input logic [7:0] a);
        return (a < 8'd16) ? m[a[3:0]] : 8'h00;
    endfunction

    task automatic addr_phase(input logic [7:0] a);
        ad = 1'b0; bus_in = a; cs_n = 1'b0;
        repeat (2) tick();
        wr_n = 1'b0;
        repeat (4) tick();
        wr_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        clr_mon();
        addr_phase(a);
        ad = 1'b1; bus_in = d;
        repeat (2) tick();
        wr_n = 1'b0;
        repeat (4) tick();
        wr_n = 1'b1;
        repeat (6) tick();
        cs_n = 1'b1;
        repeat (2) tick();
        checki("wr_evt_count", evt_cnt, 1);
        check8("evt_addr", last_ea, a);
        check8("evt_data", last_ed, d);
        checki("upd_count", upd_cnt, (a == 8'hF0) ? 1 : 0);
        checki("upd_without_evt", upd_alone, 0);
        checki("oe_during_write", stray_oe, 0);
        if (a < 8'd16) m[a[3:0]] = d;
    endtask

    task automatic bus_read(input logic [7:0] a);
        logic [7:0] exp;
        int         bad;
        exp = exp_rd(a);
        clr_mon();
        addr_phase(a);
        ad = 1'b1; cs_n = 1'b0;
        repeat (2) tick();
        rd_n = 1'b0;
        oe_allow = 1'b1;
        repeat (3) tick();
        check8("oe_entry_lag", {7'b0, bus_oe}, 8'h00);
        tick();
        check8("oe_on", {7'b0, bus_oe}, 8'h01);
        check8("rd_data", bus_out, exp);
        bad = 0;
        repeat (4) begin
            tick();
            if (bus_oe !== 1'b1 || bus_out !== exp) bad++;
        end
        checki("oe_data_stable", bad, 0);
        rd_n = 1'b1;
        tick();
        check8("oe_before_detect", {7'b0, bus_oe}, 8'h01);
        tick();
        check8("oe_drop_on_detect", {7'b0, bus_oe}, 8'h00);
        oe_allow = 1'b0;
        repeat (3) tick();
        cs_n = 1'b1;
        tick();
        checki("oe_outside_read", stray_oe, 0);
        checki("evt_during_read", evt_cnt, 0);
    endtask

    initial begin
        logic [7:0] a, d;
        reset = 1'b0;
        cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; ad = 1'b1; bus_in = 8'h00;
        for (int i = 0; i < 16; i++) m[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        clr_mon();
        tick();
        check8("rst_bus_oe", {7'b0, bus_oe}, 8'h00);
        check8("rst_bus_out", bus_out, 8'h00);
        check8("rst_upd", {7'b0, upd}, 8'h00);
        check8("rst_wr_evt", {7'b0, wr_evt}, 8'h00);
        check8("rst_evt_addr", evt_addr, 8'h00);
        check8("rst_evt_data", evt_data, 8'h00);

        bus_write(8'h03, 8'h45);
        bus_read(8'h03);
        bus_write(8'hF0, 8'h00);
        bus_read(8'h03);
        bus_write(8'h20, 8'hAA);
        bus_read(8'h20);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) != 0) a = 8'($urandom_range(0, 15));
            else if ($urandom_range(0, 1) != 0) a = 8'hF0;
            else a = 8'($urandom_range(16, 239));
            d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) != 0) bus_write(a, d);
            else bus_read(a);
        end

        // Both strobes low in the data phase: no commit, back to IDLE
        clr_mon();
        addr_phase(8'h05);
        ad = 1'b1; bus_in = 8'h77;
        repeat (2) tick();
        wr_n = 1'b0; rd_n = 1'b0;
        repeat (4) tick();
        wr_n = 1'b1; rd_n = 1'b1;
        repeat (4) tick();
        checki("proto_err_no_evt", evt_cnt, 0);
        checki("proto_err_no_oe", stray_oe, 0);
        bus_in = 8'h99;
        wr_n = 1'b0;
        repeat (4) tick();
        wr_n = 1'b1;
        repeat (5) tick();
        checki("proto_err_idle_ignores_data", evt_cnt, 0);
        cs_n = 1'b1;
        tick();
        bus_read(8'h05);

        // Chip select released mid-write aborts with no commit
        clr_mon();
        addr_phase(8'h07);
        ad = 1'b1; bus_in = 8'h5A;
        repeat (2) tick();
        wr_n = 1'b0;
        repeat (4) tick();
        cs_n = 1'b1;
        repeat (4) tick();
        wr_n = 1'b1;
        repeat (5) tick();
        checki("cs_abort_no_evt", evt_cnt, 0);
        bus_read(8'h07);

        // Reset during READ drops the drive enable asynchronously
        bus_write(8'h03, 8'hC3);
        addr_phase(8'h03);
        ad = 1'b1; cs_n = 1'b0;
        repeat (2) tick();
        rd_n = 1'b0;
        oe_allow = 1'b1;
        repeat (5) tick();
        check8("pre_reset_oe", {7'b0, bus_oe}, 8'h01);
        reset = 1'b0;
        #1;
        check8("async_reset_oe", {7'b0, bus_oe}, 8'h00);
        check8("async_reset_bus_out", bus_out, 8'h00);
        oe_allow = 1'b0;
        cs_n = 1'b1; rd_n = 1'b1; ad = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 16; i++) m[i] = 8'h00;
        bus_read(8'h03);
        bus_read(8'h00);
        bus_read(8'h0F);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
